// File: rtl/cpu_debug_action_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_debug_action_sequencer
//
// Purpose:
//   Collects the single-cycle take_action_* strobes and the jdo word coming
//   from the CPU debug slave, keeps one pending command per action source,
//   and serialises them onto a single valid/ready command port using
//   round-robin arbitration. A command that is re-strobed before it is
//   issued is overwritten (latest wins) and flagged in ovf_sticky. A stall
//   watchdog discards a presented command that is not accepted in time.
//
// Ports:
//   clk                    in   system clock
//   reset                  in   synchronous active-high reset
//   en                     in   grant enable (capture continues when low)
//   jdo                    in   debug data word, sampled with any strobe
//   take_action_ocimem_a   in   source 0 strobe
//   take_action_ocimem_b   in   source 1 strobe
//   take_action_break_a    in   source 2 strobe
//   take_action_break_b    in   source 3 strobe
//   take_action_break_c    in   source 4 strobe
//   take_action_tracectrl  in   source 5 strobe
//   cmd_ready              in   consumer accepts the command this cycle
//   cmd_valid              out  command presented
//   cmd_src                out  source index 0..5 of the presented command
//   cmd_data               out  jdo captured with that command
//   ovf_clr                in   clears ovf_sticky
//   ovf_sticky             out  per-source overwrite flags
//   timeout_err            out  one-cycle pulse when the watchdog drops
//   busy                   out  any pending command or cmd_valid set
// ---------------------------------------------------------------------------
module cpu_debug_action_sequencer #(
  parameter int JDO_W   = 38,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [JDO_W-1:0] jdo,
  input  logic             take_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic             take_action_break_a,
  input  logic             take_action_break_b,
  input  logic             take_action_break_c,
  input  logic             take_action_tracectrl,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [2:0]       cmd_src,
  output logic [JDO_W-1:0] cmd_data,
  input  logic             ovf_clr,
  output logic [5:0]       ovf_sticky,
  output logic             timeout_err,
  output logic             busy
);

  localparam int NSRC = 6;

  // Counter value on which a stalled command is dropped; unused when the
  // watchdog is disabled (TIMEOUT == 0).
  localparam logic            WD_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX  = '1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NSRC-1:0]  r_pending;
  logic [JDO_W-1:0] r_payload [NSRC];
  logic [2:0]       r_last_grant;
  logic             r_cmd_valid;
  logic [2:0]       r_cmd_src;
  logic [JDO_W-1:0] r_cmd_data;
  logic [NSRC-1:0]  r_ovf;
  logic             r_timeout_err;
  logic [TO_W-1:0]  r_stall_cnt;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [NSRC-1:0] w_strobe;
  logic            w_stalled;
  logic            w_drop;
  logic            w_stage_free;
  logic            w_grant_vld;
  logic [2:0]      w_grant_idx;
  logic [NSRC-1:0] w_grant_onehot;
  logic [NSRC-1:0] w_ovf_set;

  assign w_strobe = {take_action_tracectrl, take_action_break_c,
                     take_action_break_b,   take_action_break_a,
                     take_action_ocimem_b,  take_action_ocimem_a};

  assign w_stalled    = r_cmd_valid & ~cmd_ready;
  assign w_drop       = WD_EN & w_stalled & (r_stall_cnt == TMO_LAST);
  assign w_stage_free = ~r_cmd_valid | cmd_ready;

  // Round-robin search: walk the offsets from farthest to nearest so that the
  // nearest pending source after r_last_grant is the final assignment.
  // A drop can only happen while stalled, so it never coincides with a grant;
  // the explicit term keeps that intent visible.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = 3'd0;
    if (en && w_stage_free && !w_drop) begin
      for (int k = NSRC; k >= 1; k--) begin
        idx = int'(r_last_grant) + k;
        if (idx >= NSRC) begin
          idx = idx - NSRC;
        end
        if (r_pending[idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = 3'(idx);
        end
      end
    end
  end

  assign w_grant_onehot = w_grant_vld ? (NSRC'(1) << w_grant_idx) : '0;

  // An overwrite is only flagged when the entry is pending and is not being
  // handed to the output stage on this very edge (that case re-arms cleanly).
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_ovf
      assign w_ovf_set[gi] = w_strobe[gi] & r_pending[gi] & ~w_grant_onehot[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_payload[i] <= '0;
      end
      r_last_grant  <= 3'd5;
      r_cmd_valid   <= 1'b0;
      r_cmd_src     <= 3'd0;
      r_cmd_data    <= '0;
      r_ovf         <= '0;
      r_timeout_err <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      // Set wins over the grant clear, so a same-cycle re-strobe stays pending.
      r_pending <= (r_pending & ~w_grant_onehot) | w_strobe;

      // The payload is always loaded on a strobe; the output stage reads the
      // pre-edge value, so a colliding grant still carries the old word.
      for (int i = 0; i < NSRC; i++) begin
        if (w_strobe[i]) begin
          r_payload[i] <= jdo;
        end
      end

      r_ovf         <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
      r_timeout_err <= w_drop;

      if (w_drop) begin
        r_cmd_valid <= 1'b0;
      end else if (w_grant_vld) begin
        r_cmd_valid  <= 1'b1;
        r_cmd_src    <= w_grant_idx;
        r_cmd_data   <= r_payload[w_grant_idx];
        r_last_grant <= w_grant_idx;
      end else if (w_stage_free) begin
        r_cmd_valid <= 1'b0;
      end

      if (w_stalled) begin
        if (w_drop) begin
          r_stall_cnt <= '0;
        end else if (r_stall_cnt != CNT_MAX) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd_valid   = r_cmd_valid;
  assign cmd_src     = r_cmd_src;
  assign cmd_data    = r_cmd_data;
  assign ovf_sticky  = r_ovf;
  assign timeout_err = r_timeout_err;
  assign busy        = (|r_pending) | r_cmd_valid;

endmodule

// File: doc/cpu_debug_action_sequencer.md
Name: cpu_debug_action_sequencer

Overview:
- Collects the single-cycle take_action_* strobes and the 38-bit jdo word from the CPU debug slave sysclk domain.
- Holds one pending command per action source.
- Serialises the pending commands onto one valid/ready command port toward the OCI register/memory logic, using round-robin arbitration.
- Adds overwrite detection, a stall watchdog and an enable gate. It sits between the debug slave wrapper outputs and the OCI command consumers.

Parameters:
- JDO_W, 38, width of the jdo payload captured per command.
- TO_W, 16, width of the stall watchdog counter.
- TIMEOUT, 1023, cycles cmd_valid may stall before the command is dropped; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- en  in  1  grant enable; low = capture continues, no new grants issued
- jdo  in  JDO_W  debug data word, sampled with any strobe
- take_action_ocimem_a  in  1  source 0 strobe
- take_action_ocimem_b  in  1  source 1 strobe
- take_action_break_a  in  1  source 2 strobe
- take_action_break_b  in  1  source 3 strobe
- take_action_break_c  in  1  source 4 strobe
- take_action_tracectrl  in  1  source 5 strobe
- cmd_ready  in  1  consumer accepts the command this cycle
- cmd_valid  out  1  command presented
- cmd_src  out  3  source index 0..5 of the presented command
- cmd_data  out  JDO_W  jdo captured with that command
- ovf_clr  in  1  clears ovf_sticky
- ovf_sticky  out  6  per-source overwrite flags
- timeout_err  out  1  one-cycle pulse when the watchdog drops a command
- busy  out  1  high when any pending bit or cmd_valid is set

Behaviour:

Reset:
- Synchronous reset clears pending[5:0], all payload registers, cmd_valid, cmd_src, cmd_data, ovf_sticky, timeout_err and the stall counter.
- The round-robin pointer last_grant resets to 5, so the first grant searches from source 0.

Capture:
- A strobe on source i at rising edge k sets pending[i] and loads payload[i] with jdo at that edge.
- Multiple sources may strobe in the same cycle; each captures the same jdo.

Output stage:
- The output stage is "free" when cmd_valid=0, or when cmd_valid=1 and cmd_ready=1.
- When it is free, en=1 and some pending bit is set, the next pending index after last_grant (cyclic 0..5) is granted on that edge:
  - cmd_valid<=1, cmd_src<=i, cmd_data<=payload[i];
  - pending[i]<=0; last_grant<=i.
- If the stage is free and nothing is granted, cmd_valid<=0.
- Back-to-back transfers occur when cmd_ready is held high.
- Latency: a strobe captured at edge k gives cmd_valid high after edge k+1 at the earliest.

Simultaneous set and grant:
- If source i strobes in the same cycle its pending entry is granted, the old payload goes out.
- pending[i] stays 1 with the new jdo (set wins over clear). No overflow is flagged.

Overwrite:
- If source i strobes while pending[i]=1 and i is not granted that cycle, payload[i] is overwritten with the new jdo (latest wins) and ovf_sticky[i]<=1.
- ovf_clr clears all ovf_sticky bits. A set in the same cycle as ovf_clr wins.

Stall hold:
- cmd_src and cmd_data are stable while cmd_valid=1 and cmd_ready=0.
- en=0 does not withdraw a presented command.

Watchdog:
- The stall counter increments each cycle that cmd_valid=1 and cmd_ready=0, and clears on any other cycle.
- When TIMEOUT!=0 and the counter equals TIMEOUT-1 while still stalled, on that edge:
  - cmd_valid<=0, timeout_err<=1 for one cycle, counter<=0.
  - The command is discarded; no regrant of the discarded command.
- A new grant may not occur on the same edge as the drop. Arbitration resumes the next cycle.
- The counter saturates at 2^TO_W-1 when TIMEOUT=0.

busy = |pending | cmd_valid (combinational).

Test Plan:
- Reset then single strobe: pulse take_action_break_b with jdo=0x2A_DEAD_BEEF, cmd_ready=1 -> cmd_valid high one cycle after capture, cmd_src=3, cmd_data=0x2ADEADBEEF, busy falls the next cycle.
- Round-robin: all six strobes in one cycle with cmd_ready=1 -> grants in order 0,1,2,3,4,5 on consecutive cycles. Then strobe sources 0 and 5 together -> 0 is granted first (last_grant=5 wraps).
- Stall and overwrite: cmd_ready=0, strobe ocimem_a twice with jdo=1 then jdo=2 while it is pending behind a stalled command -> ovf_sticky[0]=1. Later cmd_data=2. ovf_clr -> ovf_sticky=0.
- Set-and-grant collision: strobe source 2 again exactly on its grant cycle -> first command carries the old jdo, pending[2] remains set with the new jdo, ovf_sticky[2]=0.
- Watchdog: TIMEOUT=8, cmd_ready held low -> cmd_valid drops after 8 stalled cycles, timeout_err pulses exactly once, next pending source is granted the following cycle.
- Enable and reset mid-operation: en=0 with three pending sources -> no cmd_valid. Assert reset while cmd_valid=1 and ready low -> all outputs 0 next cycle, a strobe after reset grants source index 0 first.
